// File: rtl/cacheline_adapter_pkg.sv
// Shared types and sizing for the cacheline-to-burst adapter.
// One 256-bit line moves as four 64-bit bmem beats.
package cacheline_adapter_pkg;

    localparam int LINE_WIDTH = 256;
    localparam int BEAT_WIDTH = 64;
    localparam int BEATS      = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W      = $clog2(BEATS);
    localparam int ADDR_W     = 32;

    localparam logic [CNT_W-1:0]  LAST_BEAT   = CNT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK   = ~ADDR_W'(LINE_WIDTH / 8 - 1);

    typedef logic [LINE_WIDTH-1:0] line_t;
    typedef logic [BEAT_WIDTH-1:0] beat_t;
    typedef logic [ADDR_W-1:0]     addr_t;
    typedef logic [CNT_W-1:0]      beat_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        WR_BURST,
        RD_CMD,
        RD_WAIT,
        DONE
    } adapter_state_t;

    function automatic addr_t line_align(input addr_t a);
        return a & LINE_MASK;
    endfunction

endpackage

// File: rtl/line_beat_buffer.sv
// Purpose: line-wide register with full-line load, per-beat write and per-beat read.
// Latency: writes visible the cycle after the enable; beat read port is combinational.
// Backpressure: none; the owner decides when to load or fill.
module line_beat_buffer
    import cacheline_adapter_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      load_en,
    input  line_t     load_line,
    input  logic      slice_wr_en,
    input  beat_idx_t slice_wr_idx,
    input  beat_t     slice_wr_dat,
    input  beat_idx_t slice_rd_idx,
    output beat_t     slice_rd_dat,
    output line_t     line
);

    logic [BEATS-1:0][BEAT_WIDTH-1:0] line_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
        end else if (load_en) begin
            line_q <= load_line;
        end else if (slice_wr_en) begin
            line_q[slice_wr_idx] <= slice_wr_dat;
        end
    end

    assign slice_rd_dat = line_q[slice_rd_idx];
    assign line         = line_q;

endmodule

// File: rtl/cacheline_adapter.sv
// Purpose: turns one dfp cacheline read/write into a 4-beat 64-bit bmem burst.
// Latency: write = 4 beats + 1 resp cycle; read = cmd + L + 4 beats + 1 resp cycle.
// Backpressure: bmem_ready low stalls the current command/beat; dfp requests are held by the cache.
module cacheline_adapter
    import cacheline_adapter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     dfp_addr,
    input  logic                  dfp_read,
    input  logic                  dfp_write,
    input  logic [LINE_WIDTH-1:0] dfp_wdata,
    output logic [LINE_WIDTH-1:0] dfp_rdata,
    output logic                  dfp_resp,
    output logic [ADDR_W-1:0]     bmem_addr,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [BEAT_WIDTH-1:0] bmem_wdata,
    input  logic                  bmem_ready,
    input  logic [ADDR_W-1:0]     bmem_raddr,
    input  logic [BEAT_WIDTH-1:0] bmem_rdata,
    input  logic                  bmem_rvalid
);

    adapter_state_t state_q, state_d;
    beat_idx_t      cnt_q;
    addr_t          addr_q;
    line_t          rdata_q;
    line_t          buf_line;
    line_t          rd_line;
    beat_t          buf_beat;
    logic           rd_hit;
    logic           beat_adv;
    logic           req_take;
    logic           line_fill_done;

    // Only beats tagged with our own line address count toward the fill.
    assign rd_hit         = bmem_rvalid && (bmem_raddr == addr_q);
    assign req_take       = (state_q == IDLE) && (dfp_write || dfp_read);
    assign line_fill_done = (state_q == RD_WAIT) && rd_hit && (cnt_q == LAST_BEAT);

    always_comb begin
        state_d  = state_q;
        beat_adv = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dfp_write) begin
                    state_d = WR_BURST;
                end else if (dfp_read) begin
                    state_d = RD_CMD;
                end
            end
            WR_BURST: begin
                if (bmem_ready) begin
                    beat_adv = 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            RD_CMD: begin
                if (bmem_ready) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (rd_hit) begin
                    beat_adv = 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The final beat lands in the top slice; fold it in directly so the
    // response line is ready in the DONE cycle without an extra register stage.
    always_comb begin
        rd_line = buf_line;
        rd_line[LINE_WIDTH-1 -: BEAT_WIDTH] = bmem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (beat_adv) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (req_take) begin
                addr_q <= line_align(dfp_addr);
            end
            if (line_fill_done) begin
                rdata_q <= rd_line;
            end
        end
    end

    line_beat_buffer u_buf (
        .clk          (clk),
        .rst          (rst),
        .load_en      (req_take && dfp_write),
        .load_line    (dfp_wdata),
        .slice_wr_en  ((state_q == RD_WAIT) && rd_hit),
        .slice_wr_idx (cnt_q),
        .slice_wr_dat (bmem_rdata),
        .slice_rd_idx (cnt_q),
        .slice_rd_dat (buf_beat),
        .line         (buf_line)
    );

    // Every output comes from registered state, never straight from dfp inputs.
    assign bmem_write = (state_q == WR_BURST);
    assign bmem_read  = (state_q == RD_CMD);
    assign bmem_addr  = (bmem_write || bmem_read) ? addr_q : '0;
    assign bmem_wdata = bmem_write ? buf_beat : '0;
    assign dfp_resp   = (state_q == DONE);
    assign dfp_rdata  = rdata_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter with a small in-bench bmem responder.
module tb_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    int checks = 0;
    int errors = 0;

    // memory responder state and logs
    logic [31:0] q_addr[$];
    logic [63:0] q_data[$];
    logic [31:0] wlog_a[$];
    logic [63:0] wlog_d[$];
    int          wbeats, rcmds, resps;
    logic [31:0] cmd_addr;
    logic        fill_pending, fill_now, inject_bad;
    logic [31:0] fill_addr;

    logic [255:0] line1, wline, wline2;
    logic [63:0]  b1 [4];
    int           wb_idx [5];

    always #5 clk = ~clk;

    cacheline_adapter dut (
        .clk         (clk),
        .rst         (rst),
        .dfp_addr    (dfp_addr),
        .dfp_read    (dfp_read),
        .dfp_write   (dfp_write),
        .dfp_wdata   (dfp_wdata),
        .dfp_rdata   (dfp_rdata),
        .dfp_resp    (dfp_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] beat_val(input logic [31:0] a, input int k);
        return {a, 32'hC0DE_0000 | k};
    endfunction

    function automatic logic [255:0] exp_line(input logic [31:0] a);
        return {beat_val(a, 3), beat_val(a, 2), beat_val(a, 1), beat_val(a, 0)};
    endfunction

    function automatic logic [63:0] slice(input logic [255:0] l, input int k);
        return l[k*64 +: 64];
    endfunction

    task automatic clear_logs();
        wlog_a.delete();
        wlog_d.delete();
        wbeats = 0;
        rcmds  = 0;
        resps  = 0;
        cmd_addr = '0;
    endtask

    // Memory with read latency 1 and always-ready; cache drops its request on dfp_resp.
    task automatic run_bus(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            if (q_addr.size() > 0) begin
                bmem_rvalid = 1'b1;
                bmem_raddr  = q_addr.pop_front();
                bmem_rdata  = q_data.pop_front();
            end else begin
                bmem_rvalid = 1'b0;
                bmem_raddr  = '0;
                bmem_rdata  = '0;
            end
            if (bmem_write && bmem_ready) begin
                wbeats++;
                wlog_a.push_back(bmem_addr);
                wlog_d.push_back(bmem_wdata);
            end
            if (bmem_read && bmem_ready) begin
                rcmds++;
                cmd_addr = bmem_addr;
                for (int k = 0; k < 4; k++) begin
                    if (inject_bad && k == 2) begin
                        q_addr.push_back(bmem_addr ^ 32'h20);
                        q_data.push_back(64'hBAD0_BAD0_BAD0_BAD0);
                    end
                    q_addr.push_back(bmem_addr);
                    q_data.push_back(beat_val(bmem_addr, k));
                end
            end
            if (dfp_resp) begin
                resps++;
                dfp_read  = 1'b0;
                dfp_write = 1'b0;
                if (fill_pending) begin
                    fill_pending = 1'b0;
                    fill_now     = 1'b1;
                end
            end else if (fill_now) begin
                fill_now  = 1'b0;
                dfp_addr  = fill_addr;
                dfp_read  = 1'b1;
            end
            tick();
        end
        bmem_rvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
        bmem_ready = 1'b1; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
        fill_pending = 1'b0; fill_now = 1'b0; inject_bad = 1'b0; fill_addr = '0;
        clear_logs();
        b1[0] = 64'h1111_1111_1111_1111;
        b1[1] = 64'h2222_2222_2222_2222;
        b1[2] = 64'h3333_3333_3333_3333;
        b1[3] = 64'h4444_4444_4444_4444;
        line1 = {b1[3], b1[2], b1[1], b1[0]};
        wline = {64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002,
                 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0000};
        wline2 = ~wline;
        wb_idx = '{0, 1, 1, 2, 3};
        tick();
        tick();

        chk("rst_resp",  dfp_resp,   0);
        chk("rst_read",  bmem_read,  0);
        chk("rst_write", bmem_write, 0);
        chk("rst_addr",  bmem_addr,  0);
        chk("rst_wdata", bmem_wdata, 0);
        chk("rst_rdata", dfp_rdata,  0);
        rst = 1'b0;
        tick();

        // Read, L=2: cmd at cycle 1, beats 3..6, resp at 7
        dfp_addr = 32'h0000_1234;
        dfp_read = 1'b1;
        chk("t1_c0_read", bmem_read, 0);
        tick();
        for (int c = 1; c <= 9; c++) begin
            bmem_rvalid = (c >= 3 && c <= 6);
            bmem_raddr  = 32'h0000_1220;
            bmem_rdata  = '0;
            if (c >= 3 && c <= 6) bmem_rdata = b1[c-3];
            chk($sformatf("t1_c%0d_resp", c), dfp_resp, (c == 7));
            chk($sformatf("t1_c%0d_read", c), bmem_read, (c == 1));
            if (c == 1) chk("t1_cmd_addr", bmem_addr, 32'h0000_1220);
            if (c == 7) begin
                chk("t1_rdata", dfp_rdata, line1);
                dfp_read = 1'b0;
            end
            tick();
        end
        bmem_rvalid = 1'b0;

        // Write with ready low on beat 1: beats at 1..5 (beat 1 twice), resp at 6
        dfp_addr  = 32'h0000_2010;
        dfp_wdata = wline;
        dfp_write = 1'b1;
        tick();
        for (int c = 1; c <= 7; c++) begin
            bmem_ready = (c != 2);
            chk($sformatf("t2_c%0d_write", c), bmem_write, (c <= 5));
            if (c <= 5) begin
                chk($sformatf("t2_c%0d_wdata", c), bmem_wdata, slice(wline, wb_idx[c-1]));
                chk($sformatf("t2_c%0d_addr", c), bmem_addr, 32'h0000_2000);
            end
            chk($sformatf("t2_c%0d_resp", c), dfp_resp, (c == 6));
            if (c == 6) dfp_write = 1'b0;
            tick();
        end
        bmem_ready = 1'b1;
        chk("t2_rdata_hold", dfp_rdata, line1);

        // Writeback followed by fill on the next cycle
        clear_logs();
        dfp_addr     = 32'h8000_0040;
        dfp_wdata    = wline2;
        dfp_write    = 1'b1;
        fill_pending = 1'b1;
        fill_addr    = 32'h8000_0100;
        run_bus(20);
        chk("t3_wbeats", wbeats, 4);
        chk("t3_rcmds", rcmds, 1);
        chk("t3_resps", resps, 2);
        chk("t3_waddr0", wlog_a[0], 32'h8000_0040);
        chk("t3_wdata0", wlog_d[0], slice(wline2, 0));
        chk("t3_wdata3", wlog_d[3], slice(wline2, 3));
        chk("t3_cmd_addr", cmd_addr, 32'h8000_0100);
        chk("t3_rdata", dfp_rdata, exp_line(32'h8000_0100));

        // Simultaneous read and write: write wins
        clear_logs();
        dfp_addr  = 32'h0000_6000;
        dfp_wdata = wline;
        dfp_write = 1'b1;
        dfp_read  = 1'b1;
        run_bus(12);
        chk("t4_wbeats", wbeats, 4);
        chk("t4_rcmds", rcmds, 0);
        chk("t4_resps", resps, 1);
        chk("t4_wdata2", wlog_d[2], slice(wline, 2));

        // Stray beats in IDLE/RD_CMD plus a foreign beat inside the burst
        clear_logs();
        q_addr.push_back(32'h0000_3000); q_data.push_back(64'hFEED_FEED_FEED_FEED);
        q_addr.push_back(32'h0000_3000); q_data.push_back(64'hFACE_FACE_FACE_FACE);
        inject_bad = 1'b1;
        dfp_addr   = 32'h0000_3008;
        dfp_read   = 1'b1;
        run_bus(16);
        inject_bad = 1'b0;
        chk("t5_rcmds", rcmds, 1);
        chk("t5_resps", resps, 1);
        chk("t5_rdata", dfp_rdata, exp_line(32'h0000_3000));
        chk("t5_q_empty", q_addr.size(), 0);

        // Reset in the middle of a write burst
        dfp_addr  = 32'h0000_4000;
        dfp_wdata = wline;
        dfp_write = 1'b1;
        tick();
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("t6_c%0d_wdata", c), bmem_wdata, slice(wline, c - 1));
            tick();
        end
        rst       = 1'b1;
        dfp_write = 1'b0;
        tick();
        chk("t6_rst_resp",  dfp_resp,   0);
        chk("t6_rst_read",  bmem_read,  0);
        chk("t6_rst_write", bmem_write, 0);
        chk("t6_rst_addr",  bmem_addr,  0);
        chk("t6_rst_wdata", bmem_wdata, 0);
        chk("t6_rst_rdata", dfp_rdata,  0);
        rst = 1'b0;
        tick();
        chk("t6_idle_write", bmem_write, 0);
        chk("t6_idle_read",  bmem_read,  0);
        clear_logs();
        dfp_addr = 32'h0000_5000;
        dfp_read = 1'b1;
        run_bus(14);
        chk("t6_rd_rcmds", rcmds, 1);
        chk("t6_rd_wbeats", wbeats, 0);
        chk("t6_rd_resps", resps, 1);
        chk("t6_rd_rdata", dfp_rdata, exp_line(32'h0000_5000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
